// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_pkg
// Description : Shared definitions for the reset/clock-enable sequencer:
//               FSM state encoding, default delay constants and the constant
//               helpers used to size the delay timer and block index.
// Revision    : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

    // FSM state encoding (explicit 3-bit width)
    typedef logic [2:0] state_t;

    localparam state_t S_BOOT_WAIT   = 3'd0;
    localparam state_t S_BOOT_EN     = 3'd1;
    localparam state_t S_BOOT_REL    = 3'd2;
    localparam state_t S_RUN         = 3'd3;
    localparam state_t S_SOFT_GATE   = 3'd4;
    localparam state_t S_SOFT_HOLD   = 3'd5;
    localparam state_t S_SOFT_UNGATE = 3'd6;
    localparam state_t S_SOFT_ACK_W  = 3'd7;

    // Default delay settings
    localparam int c_DEF_NUM_BLOCKS  = 4;
    localparam int c_DEF_GATE_DLY    = 2;
    localparam int c_DEF_RELEASE_DLY = 8;
    localparam int c_DEF_HOLD_CYCLES = 4;

    // Ceiling log2 for constant sizing; returns 0 for values <= 1
    function automatic int seq_clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    function automatic int seq_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_seq_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_timer
// Description : Loadable down-counter shared by every delay of the reset
//               sequencer. Counts down to zero and parks there; o_zero flags
//               the cycle in which the programmed delay has expired.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_load          - load i_load_val (wins over counting)
//               i_load_val      - value to load (delay minus one)
//               o_zero          - counter is at zero
// Revision    : 1.0 - initial release
// ============================================================================
module seq_timer #(
    parameter int                WIDTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [WIDTH-1:0]  i_load_val,
    output logic              o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_ctrl
// Description : Reset/clock-enable sequencer. After the domain reset it
//               enables the clock and then releases the reset of each
//               downstream block in turn, then serves masked soft-reset
//               requests over a four-phase valid/ack handshake.
// Ports       : clk, rst_n   - domain clock, synchronized async active-low reset
//               soft_vld     - soft-reset request valid (held until ack)
//               soft_req     - mask of blocks to soft-reset
//               soft_ack     - request complete (level, until soft_vld drops)
//               busy         - boot or soft sequence in progress
//               seq_done     - boot sequence complete
//               blk_clk_en   - per-block clock-gate enable
//               blk_rst      - per-block reset, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_BLOCKS  = c_DEF_NUM_BLOCKS,
    parameter int GATE_DLY    = c_DEF_GATE_DLY,
    parameter int RELEASE_DLY = c_DEF_RELEASE_DLY,
    parameter int HOLD_CYCLES = c_DEF_HOLD_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_vld,
    input  logic [NUM_BLOCKS-1:0] soft_req,
    output logic                  soft_ack,
    output logic                  busy,
    output logic                  seq_done,
    output logic [NUM_BLOCKS-1:0] blk_clk_en,
    output logic [NUM_BLOCKS-1:0] blk_rst
);

    localparam int c_TMR_W = seq_clog2(seq_max3(GATE_DLY, RELEASE_DLY, HOLD_CYCLES) + 1);
    localparam int c_IDX_W = (NUM_BLOCKS > 1) ? seq_clog2(NUM_BLOCKS) : 1;

    // Timer load values are "delay - 1": the transition fires on the edge
    // that finds the counter at zero, exactly DLY edges after the load edge.
    localparam logic [c_TMR_W-1:0] c_GATE_LD = c_TMR_W'(GATE_DLY - 1);
    localparam logic [c_TMR_W-1:0] c_REL_LD  = c_TMR_W'(RELEASE_DLY - 1);
    localparam logic [c_TMR_W-1:0] c_HOLD_LD = c_TMR_W'(HOLD_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_LAST    = c_IDX_W'(NUM_BLOCKS - 1);

    state_t                r_state,  w_state_nxt;
    logic [c_IDX_W-1:0]    r_idx,    w_idx_nxt;
    logic [NUM_BLOCKS-1:0] r_mask,   w_mask_nxt;
    logic [NUM_BLOCKS-1:0] r_en,     w_en_nxt;
    logic [NUM_BLOCKS-1:0] r_rst,    w_rst_nxt;
    logic                  r_done,   w_done_nxt;
    logic                  r_ack,    w_ack_nxt;
    logic                  r_busy,   w_busy_nxt;
    logic                  w_accept;
    logic                  w_tmr_load;
    logic [c_TMR_W-1:0]    w_tmr_val;
    logic                  w_tmr_zero;

    // Reset preloads the boot settle delay so the first enable lands on the
    // RELEASE_DLY-th edge, the same spacing used between later releases.
    seq_timer #(
        .WIDTH   (c_TMR_W),
        .RST_VAL (c_REL_LD)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_mask_nxt  = r_mask;
        w_en_nxt    = r_en;
        w_rst_nxt   = r_rst;
        w_done_nxt  = r_done;
        w_ack_nxt   = r_ack;
        w_busy_nxt  = r_busy;
        w_accept    = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;

        case (r_state)
            S_BOOT_WAIT: begin
                if (w_tmr_zero) begin
                    w_en_nxt[r_idx] = 1'b1;
                    w_tmr_load      = 1'b1;
                    w_tmr_val       = c_GATE_LD;
                    w_state_nxt     = S_BOOT_EN;
                end
            end
            S_BOOT_EN: begin
                if (w_tmr_zero) begin
                    w_rst_nxt[r_idx] = 1'b1;
                    w_tmr_load       = 1'b1;
                    w_tmr_val        = c_REL_LD;
                    w_state_nxt      = S_BOOT_REL;
                end
            end
            S_BOOT_REL: begin
                if (w_tmr_zero) begin
                    if (r_idx == c_LAST) begin
                        // A request held pending through boot is taken on
                        // this same edge, so busy never drops in between.
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_RUN;
                        w_accept    = soft_vld;
                    end else begin
                        w_idx_nxt            = r_idx + c_IDX_W'(1);
                        w_en_nxt[w_idx_nxt]  = 1'b1;
                        w_tmr_load           = 1'b1;
                        w_tmr_val            = c_GATE_LD;
                        w_state_nxt          = S_BOOT_EN;
                    end
                end
            end
            S_RUN: begin
                w_accept = soft_vld;
            end
            S_SOFT_GATE: begin
                if (w_tmr_zero) begin
                    w_rst_nxt   = r_rst & ~r_mask;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = c_HOLD_LD;
                    w_state_nxt = S_SOFT_HOLD;
                end
            end
            S_SOFT_HOLD: begin
                if (w_tmr_zero) begin
                    w_en_nxt    = r_en | r_mask;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = c_GATE_LD;
                    w_state_nxt = S_SOFT_UNGATE;
                end
            end
            S_SOFT_UNGATE: begin
                if (w_tmr_zero) begin
                    w_rst_nxt   = r_rst | r_mask;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = S_SOFT_ACK_W;
                end
            end
            S_SOFT_ACK_W: begin
                if (!soft_vld) begin
                    w_ack_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_BOOT_WAIT;
            end
        endcase

        if (w_accept) begin
            w_mask_nxt = soft_req;
            w_busy_nxt = 1'b1;
            w_tmr_load = 1'b1;
            if (soft_req == '0) begin
                // Empty mask: skip the gate/hold phases; the zero-length
                // ungate wait yields the ack one edge after accept.
                w_tmr_val   = '0;
                w_state_nxt = S_SOFT_UNGATE;
            end else begin
                w_en_nxt    = r_en & ~soft_req;
                w_tmr_val   = c_GATE_LD;
                w_state_nxt = S_SOFT_GATE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT_WAIT;
            r_idx   <= '0;
            r_mask  <= '0;
            r_en    <= '0;
            r_rst   <= '0;
            r_done  <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_mask  <= w_mask_nxt;
            r_en    <= w_en_nxt;
            r_rst   <= w_rst_nxt;
            r_done  <= w_done_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign soft_ack   = r_ack;
    assign busy       = r_busy;
    assign seq_done   = r_done;
    assign blk_clk_en = r_en;
    assign blk_rst    = r_rst;

endmodule
`default_nettype wire
